// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined ARM shifter: shift type codes, the
// side-band record carried with each operand, and the per-stage mux-level split.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef struct packed {
    logic [1:0] typ;
    logic       zero;
    logic       carry;
  } side_t;

  // Levels owned by a stage; earlier stages absorb the remainder.
  function automatic int unsigned stage_levels(input int unsigned stage,
                                               input int unsigned stages,
                                               input int unsigned total);
    return total / stages + ((stage < total % stages) ? 1 : 0);
  endfunction

  function automatic int unsigned stage_first_level(input int unsigned stage,
                                                    input int unsigned stages,
                                                    input int unsigned total);
    return stage * (total / stages) +
           ((stage < total % stages) ? stage : total % stages);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One register slice of the shifter: applies its share of the log2(WIDTH)
// mux levels and registers data, remaining amount and side-band.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOG_W     = 5,
  parameter int unsigned FIRST_LVL = 0,
  parameter int unsigned NUM_LVL   = 1,
  parameter bit          IS_LAST   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LOG_W-1:0] amt_i,
  input  side_t            side_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LOG_W-1:0] amt_o,
  output side_t            side_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [LOG_W-1:0] amt_q;
  side_t            side_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] lvl_data [NUM_LVL+1];

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0] typ,
                                                input int unsigned sh);
    case (typ)
      SH_LSL:  return d << sh;
      SH_LSR:  return d >> sh;
      SH_ASR:  return WIDTH'($signed(d) >>> sh);
      default: return (d >> sh) | (d << (WIDTH - sh));
    endcase
  endfunction

  assign lvl_data[0] = data_i;

  for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
    localparam int unsigned LVL = FIRST_LVL + k;
    assign lvl_data[k+1] = amt_i[LVL] ? shift_by(lvl_data[k], side_i.typ, 1 << LVL)
                                      : lvl_data[k];
  end

  // Forced-zero cases are resolved only when leaving the final slice.
  if (IS_LAST) begin : g_last
    assign data_d = side_i.zero ? '0 : lvl_data[NUM_LVL];
  end else begin : g_mid
    assign data_d = lvl_data[NUM_LVL];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      side_q  <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        amt_q  <= amt_i;
        side_q <= side_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign side_o  = side_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined ARM shifter-operand unit (LSL/LSR/ASR/ROR/RRX with carry-out)
// with valid/ready on both sides; the whole pipe freezes on output stall.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AMT_W  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [1:0]       shift_type,
  input  logic             imm_form,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_result,
  output logic             carry_out
);

  localparam int unsigned LOG_W = $clog2(WIDTH);
  localparam logic [LOG_W-1:0] AMT_MAX = LOG_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] AMT_W_VAL = AMT_W'(WIDTH);

  logic             stall;
  logic             advance;
  logic             amt_zero;
  logic             amt_lt_w;
  logic             amt_eq_w;
  logic [LOG_W-1:0] amt_lo;
  logic [LOG_W-1:0] idx_lsl;
  logic [LOG_W-1:0] idx_m1;
  logic [WIDTH-1:0] fe_data;
  logic [LOG_W-1:0] fe_amt;
  side_t            fe_side;

  logic             valid_s [STAGES];
  logic [WIDTH-1:0] data_s  [STAGES];
  logic [LOG_W-1:0] amt_s   [STAGES];
  side_t            side_s  [STAGES];

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~reset & ~stall;

  assign amt_zero = (shift_amt == '0);
  assign amt_lt_w = (shift_amt < AMT_W_VAL);
  assign amt_eq_w = (shift_amt == AMT_W_VAL);
  assign amt_lo   = shift_amt[LOG_W-1:0];
  // W - a modulo W, and a - 1; only consulted when 1 <= a (mod W) <= W-1.
  assign idx_lsl  = ~amt_lo + LOG_W'(1);
  assign idx_m1   = amt_lo - LOG_W'(1);

  // Reduce every request to a shift below WIDTH plus forced result/carry.
  always_comb begin
    fe_data       = shift_in;
    fe_amt        = '0;
    fe_side.typ   = shift_type;
    fe_side.zero  = 1'b0;
    fe_side.carry = carry_in;
    if (amt_zero) begin
      if (imm_form && shift_type == SH_LSR) begin
        fe_side.zero  = 1'b1;
        fe_side.carry = shift_in[WIDTH-1];
      end else if (imm_form && shift_type == SH_ASR) begin
        fe_amt        = AMT_MAX;
        fe_side.carry = shift_in[WIDTH-1];
      end else if (imm_form && shift_type == SH_ROR) begin
        fe_data       = {carry_in, shift_in[WIDTH-1:1]};
        fe_side.carry = shift_in[0];
      end
    end else begin
      case (shift_type)
        SH_LSL: begin
          if (amt_lt_w) begin
            fe_amt        = amt_lo;
            fe_side.carry = shift_in[idx_lsl];
          end else begin
            fe_side.zero  = 1'b1;
            fe_side.carry = amt_eq_w ? shift_in[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amt_lt_w) begin
            fe_amt        = amt_lo;
            fe_side.carry = shift_in[idx_m1];
          end else begin
            fe_side.zero  = 1'b1;
            fe_side.carry = amt_eq_w ? shift_in[WIDTH-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amt_lt_w) begin
            fe_amt        = amt_lo;
            fe_side.carry = shift_in[idx_m1];
          end else begin
            fe_amt        = AMT_MAX;
            fe_side.carry = shift_in[WIDTH-1];
          end
        end
        default: begin
          fe_amt        = amt_lo;
          fe_side.carry = (amt_lo == '0) ? shift_in[WIDTH-1] : shift_in[idx_m1];
        end
      endcase
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [LOG_W-1:0] a_in;
    side_t            s_in;

    if (i == 0) begin : g_first
      assign v_in = in_valid;
      assign d_in = fe_data;
      assign a_in = fe_amt;
      assign s_in = fe_side;
    end else begin : g_next
      assign v_in = valid_s[i-1];
      assign d_in = data_s[i-1];
      assign a_in = amt_s[i-1];
      assign s_in = side_s[i-1];
    end

    shift_stage #(
      .WIDTH    (WIDTH),
      .LOG_W    (LOG_W),
      .FIRST_LVL(stage_first_level(i, STAGES, LOG_W)),
      .NUM_LVL  (stage_levels(i, STAGES, LOG_W)),
      .IS_LAST  (i == STAGES - 1)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .advance_i(advance),
      .valid_i  (v_in),
      .data_i   (d_in),
      .amt_i    (a_in),
      .side_i   (s_in),
      .valid_o  (valid_s[i]),
      .data_o   (data_s[i]),
      .amt_o    (amt_s[i]),
      .side_o   (side_s[i])
    );
  end

  assign out_valid    = valid_s[STAGES-1];
  assign shift_result = data_s[STAGES-1];
  assign carry_out    = side_s[STAGES-1].carry;

  logic unused_tail;
  assign unused_tail = ^{amt_s[STAGES-1], side_s[STAGES-1].typ, side_s[STAGES-1].zero};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, STAGES=2): directed ARM
// shifter cases, backpressure, mid-flight reset and a randomized stream.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] shift_in;
  logic [7:0]  shift_amt;
  logic [1:0]  shift_type;
  logic        imm_form;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shift_result;
  logic        carry_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .AMT_W(8), .STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shift_in    (shift_in),
    .shift_amt   (shift_amt),
    .shift_type  (shift_type),
    .imm_form    (imm_form),
    .carry_in    (carry_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shift_result(shift_result),
    .carry_out   (carry_out)
  );

  // Reference: {carry, result} straight from the ARM shifter-operand rules.
  function automatic logic [32:0] ref_model(input logic [31:0] x, input int unsigned amt,
                                            input logic [1:0] t, input logic imm,
                                            input logic cin);
    int unsigned a = amt;
    int unsigned rr;
    logic [63:0] wide;
    if (a == 0) begin
      if (!imm || t == 2'b00) return {cin, x};
      if (t == 2'b11) return {x[0], cin, x[31:1]};
      a = 32;
    end
    case (t)
      2'b00: begin
        if (a < 32) return {x[5'(32 - a)], x << a};
        if (a == 32) return {x[0], 32'h0};
        return 33'h0;
      end
      2'b01: begin
        if (a < 32) return {x[5'(a - 1)], x >> a};
        if (a == 32) return {x[31], 32'h0};
        return 33'h0;
      end
      2'b10: begin
        if (a < 32) return {x[5'(a - 1)], 32'($signed(x) >>> a)};
        return {x[31], {32{x[31]}}};
      end
      default: begin
        rr = a % 32;
        if (rr == 0) return {x[31], x};
        wide = {x, x} >> rr;
        return {x[5'(rr - 1)], wide[31:0]};
      end
    endcase
  endfunction

  task automatic drive_req(input logic [31:0] x, input int unsigned a, input logic [1:0] t,
                           input logic imm, input logic cin);
    shift_in   = x;
    shift_amt  = 8'(a);
    shift_type = t;
    imm_form   = imm;
    carry_in   = cin;
    in_valid   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive_req(32'hFFFF_FFFF, 1, 2'b00, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (shift_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", shift_result); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry_out); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] din [10] = '{32'h8000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'hF000_000F, 32'h0000_0003, 32'h8000_0000, 32'h0000_00F0,
                              32'h1234_5678, 32'h0000_0001};
    int unsigned amt [10] = '{1, 0, 33, 40, 4, 0, 32, 36, 0, 32};
    logic [1:0] typ [10] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    logic imm [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic cin [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] eres [10] = '{32'h0000_0002, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFF00_0000,
                               32'h8000_0001, 32'h8000_0000, 32'h0000_000F, 32'h1234_5678, 32'h0};
    logic ec [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_req(din[i], amt[i], typ[i], imm[i], cin[i]);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency got=%b want=1", i, out_valid); end
      total++; if (shift_result !== eres[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, shift_result, eres[i]); end
      total++; if (carry_out !== ec[i]) begin bad++; $display("FAIL dir%0d_carry got=%b want=%b", i, carry_out, ec[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32:0] exp_q [$];
    logic [32:0] prev = 33'h0;
    logic [32:0] e;
    logic prev_stall = 1'b0;
    int sent = 0, got = 0, stalls = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (sent < 5) drive_req(32'h9000_0001 + 32'(sent * 32'h111), 32'(sent + 1), 2'(sent), 1'b0, 1'(sent));
      else in_valid = 1'b0;
      out_ready = !(cyc >= 3 && cyc < 7);
      #1;
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        total++;
        if ({carry_out, shift_result} !== prev) begin
          bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, {carry_out, shift_result}, prev);
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra got=%h want=none", {carry_out, shift_result});
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({carry_out, shift_result} !== e) begin
            bad++; $display("FAIL bp_result n=%0d got=%h want=%h", got, {carry_out, shift_result}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(shift_in, 32'(shift_amt), shift_type, imm_form, carry_in));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {carry_out, shift_result};
    end
    total++; if (got != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", got); end
    total++; if (stalls != 4) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=4", stalls); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    @(negedge clk);
    drive_req(32'h8000_0001, 1, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    drive_req(32'h0000_00F0, 4, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b want=1", out_valid); end
    #1 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", out_valid); end
    total++; if (shift_result !== 32'h0) begin bad++; $display("FAIL rm_result got=%h want=0", shift_result); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL rm_carry got=%b want=0", carry_out); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_ghost got=%b want=0", out_valid); end
    drive_req(32'h0000_00F8, 4, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_early got=%b want=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_latency got=%b want=1", out_valid); end
    total++; if (shift_result !== 32'h8000_000F) begin bad++; $display("FAIL rm_res got=%h want=8000000f", shift_result); end
    total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL rm_cout got=%b want=1", carry_out); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [32:0] exp_q [$];
    logic [32:0] prev = 33'h0;
    logic [32:0] e;
    logic prev_stall = 1'b0;
    int unsigned sel, a;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 5000 && (sent < 400 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (sent < 400) begin
        sel = $urandom_range(0, 9);
        if (sel < 2) a = 0;
        else if (sel < 4) a = $urandom_range(31, 33);
        else if (sel < 8) a = $urandom_range(1, 31);
        else a = $urandom_range(0, 255);
        drive_req($urandom, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        total++;
        if ({carry_out, shift_result} !== prev) begin
          bad++; $display("FAIL rnd_hold cyc=%0d got=%h want=%h", cyc, {carry_out, shift_result}, prev);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_extra got=%h want=none", {carry_out, shift_result});
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({carry_out, shift_result} !== e) begin
            bad++; $display("FAIL rnd_result n=%0d got=%h want=%h", got, {carry_out, shift_result}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(shift_in, 32'(shift_amt), shift_type, imm_form, carry_in));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {carry_out, shift_result};
    end
    total++;
    if (got != 400 || exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_count got=%0d want=400 pending=%0d", got, exp_q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined successor to the datapath's combinational barrel shifter.
- Implements the full ARM shifter-operand semantics: LSL, LSR, ASR and ROR, immediate-form RRX, shift amounts at or above WIDTH, and carry-out.
- Sits between the register file read and the ALU B operand in the multi-cycle/pipelined core.
- Uses a valid/ready handshake on both sides, so the execute stage can stall it.

Parameters:
- WIDTH, 32: data width; power of two, 8..64.
- AMT_W, 8: shift-amount width; must be at least clog2(WIDTH)+1 (ARM register shift uses Rs[7:0]).
- STAGES, 2: number of pipeline register stages, 1..clog2(WIDTH); latency equals STAGES cycles.

Ports:
- clk, input, 1: clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: request valid.
- in_ready, output, 1: request accepted when in_valid & in_ready.
- shift_in, input, WIDTH: operand.
- shift_amt, input, AMT_W: shift amount.
- shift_type, input, 2: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- imm_form, input, 1: 1 = immediate-encoded amount (amt 0 special meaning), 0 = register amount.
- carry_in, input, 1: current C flag.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts when out_valid & out_ready.
- shift_result, output, WIDTH: shifted value.
- carry_out, output, 1: shifter carry.

Behaviour:
- Reset (async, immediate): all stage valid bits 0, out_valid 0, shift_result 0, carry_out 0; in_ready 0 while reset is high.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational), out of reset.
- Pipeline advance: the whole pipeline advances when ~stall; bubbles are carried, not collapsed.
- Ordering: results emerge in request order; none dropped or duplicated.
- Latency: an accepted request appears on out_valid exactly STAGES cycles later if no stall intervenes. Throughput is 1 per cycle.
- Stall hold: while stalled, shift_result and carry_out hold stable.
- Front-end normalisation (before stage 1), with W = WIDTH and a = shift_amt:
  - imm_form=1, a=0: LSL means pass-through; LSR and ASR mean a=W; ROR means RRX.
  - imm_form=0, a=0: any type passes through, carry_out = carry_in.
  - Immediate-form pass-through also gives carry_out = carry_in.
- LSL:
  - 1..W-1: result = in<<a, cout = in[W-a].
  - a = W: result 0, cout = in[0].
  - a > W: result 0, cout 0.
- LSR:
  - 1..W-1: result = in>>a, cout = in[a-1].
  - a = W: result 0, cout = in[W-1].
  - a > W: result 0, cout 0.
- ASR:
  - 1..W-1: arithmetic shift, cout = in[a-1].
  - a >= W: all bits = in[W-1], cout = in[W-1].
- ROR (a != 0): r = a mod W.
  - r = 0: result = in, cout = in[W-1].
  - otherwise: rotate right by r, cout = in[r-1].
- RRX: result = {carry_in, in[W-1:1]}, cout = in[0].
- Datapath split: log2(W) mux levels split across STAGES registers as evenly as possible, with earlier stages taking the extra level.
- Side-band: the special-case result select and carry travel with the data.
- Width rules:
  - No intermediate shift by W or more is performed in hardware; special cases are forced by the decoded flags.
  - Carry index arithmetic is sized clog2(W) bits.
- Reset mid-operation: in-flight requests are discarded; first accept after deassert behaves as from cold start.

Decomposition:
- shift_pkg holds:
  - shift type localparams SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11;
  - a function for the stage-to-mux-level split.
- One sub-module, shift_stage:
  - one register slice holding valid, partial data, decoded flags and carry;
  - applies its assigned mux levels;
  - instantiated STAGES times via generate.
- Normalisation and decode are combinational logic in shift_pipe.

Test Plan:
All scenarios use WIDTH=32, STAGES=2.
- LSL, reg form: a=1, in=0x8000_0001, cin=0 -> result 0x0000_0002, cout=1; out_valid exactly 2 cycles after accept.
- LSR, imm_form=1: a=0, in=0x8000_0000 -> result 0x0000_0000, cout=1. LSL, reg form: a=33 -> result 0, cout 0.
- ASR, reg form: a=40, in=0x8000_0000 -> result 0xFFFF_FFFF, cout=1. ASR: a=4, in=0xF000_000F -> result 0xFF00_0000, cout=1.
- ROR:
  - imm_form=1, a=0 (RRX), in=0x0000_0003, cin=1 -> result 0x8000_0001, cout=1.
  - reg form, a=32, in=0x8000_0000 -> unchanged, cout=1.
  - reg form, a=36, in=0x0000_00F0 -> result 0x0000_000F, cout=0.
- Backpressure: 5 back-to-back requests, out_ready low for 4 cycles mid-stream -> in_ready low exactly while out_valid & ~out_ready; outputs stable throughout; all 5 results in order, no loss.
- Reset mid-operation: reset pulse with 2 requests in flight -> out_valid, result and carry_out drop to 0 asynchronously; the next request completes correctly 2 cycles after accept.
